// File: rtl/hilo_mac_unit_if.sv
// Purpose: request/result bundle between the instruction controller and the HI/LO MAC unit.
// Latency: none (plain wires).
// Backpressure: none; the controller must honour Busy before issuing. HILO_MOVE_EN adds mthi/mtlo signals.
interface hilo_mac_unit_if #(
  parameter int WIDTH = 32
);
  logic             HiLoWrite;
  logic             Madd;
  logic             Msub;
  logic             Signed;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
`ifdef HILO_MOVE_EN
  logic             WriteHi;
  logic             WriteLo;
  logic [WIDTH-1:0] MoveData;
`endif

  modport master (
`ifdef HILO_MOVE_EN
    output WriteHi, WriteLo, MoveData,
`endif
    output HiLoWrite, Madd, Msub, Signed, OperandA, OperandB,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
`ifdef HILO_MOVE_EN
    input  WriteHi, WriteLo, MoveData,
`endif
    input  HiLoWrite, Madd, Msub, Signed, OperandA, OperandB,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/hilo_mac_unit.sv
// Purpose: iterative shift-add mult/madd/msub unit owning the architectural HI and LO registers.
// Latency: Busy for WIDTH/RADIX_BITS+1 cycles after the request edge; Done pulses in the following cycle.
// Backpressure: strobes while Busy are dropped, never queued. Macro HILO_MOVE_EN adds mthi/mtlo moves.
module hilo_mac_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic           Clk,
  input  logic           Reset,
  hilo_mac_unit_if.slave bus
);
  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!(RADIX_BITS == 1 || RADIX_BITS == 2) || (WIDTH % RADIX_BITS) != 0) begin : g_bad_radix
    $error("hilo_mac_unit: RADIX_BITS must be 1 or 2 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MADD, OP_MSUB} op_t;

  state_t               state_q;
  op_t                  op_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   part_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 req_vld;
  op_t                  req_op;
  logic                 req_neg;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   step_add;
  logic [2*WIDTH-1:0]   part_d;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   hilo_d;

  // Request decode: exactly one strobe is a request; any combination of two or more is dropped.
  always_comb begin
    req_vld = 1'b1;
    req_op  = OP_MULT;
    case ({bus.HiLoWrite, bus.Madd, bus.Msub})
      3'b100:  req_op = OP_MULT;
      3'b010:  req_op = OP_MADD;
      3'b001:  req_op = OP_MSUB;
      default: req_vld = 1'b0;
    endcase
  end

  // Operand magnitudes and result sign; the multiply itself is always unsigned.
  always_comb begin
    a_abs   = (bus.Signed && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
    b_abs   = (bus.Signed && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;
    req_neg = bus.Signed & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
  end

  // One iteration's partial-product update plus the final signed product and HI:LO combine.
  always_comb begin
    step_add = '0;
    for (int b = 0; b < RADIX_BITS; b++) begin
      if (mplier_q[b]) step_add = step_add + (mcand_q << b);
    end
    part_d = part_q + step_add;
    prod   = neg_q ? -part_q : part_q;
    case (op_q)
      OP_MADD: hilo_d = {hi_q, lo_q} + prod;
      OP_MSUB: hilo_d = {hi_q, lo_q} - prod;
      default: hilo_d = prod;
    endcase
  end

  // Control FSM and datapath registers; Busy/Done are registered alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      part_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef HILO_MOVE_EN
          if (bus.WriteHi) hi_q <= bus.MoveData;
          if (bus.WriteLo) lo_q <= bus.MoveData;
`endif
          if (req_vld) begin
            op_q     <= req_op;
            neg_q    <= req_neg;
            mcand_q  <= {{WIDTH{1'b0}}, a_abs};
            mplier_q <= b_abs;
            part_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          part_q   <= part_d;
          mcand_q  <= mcand_q << RADIX_BITS;
          mplier_q <= mplier_q >> RADIX_BITS;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= FINISH;
        end
        FINISH: begin
          {hi_q, lo_q} <= hilo_d;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_hilo_mac_unit.sv
// Purpose: self-checking bench for hilo_mac_unit, radix-1 and radix-2 instances side by side.
// Latency: expects 33 (radix 1) / 17 (radix 2) busy cycles per operation.
// Backpressure: issues only when idle, except where dropped strobes are deliberately exercised.
module tb_hilo_mac_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] m_hl;
  logic [63:0] m2_hl;

  hilo_mac_unit_if #(.WIDTH(32)) bus ();
  hilo_mac_unit_if #(.WIDTH(32)) bus2 ();

  hilo_mac_unit #(.WIDTH(32), .RADIX_BITS(1)) dut    (.Clk(clk), .Reset(rst), .bus(bus));
  hilo_mac_unit #(.WIDTH(32), .RADIX_BITS(2)) dut_r2 (.Clk(clk), .Reset(rst), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: full 64-bit product of the (sign- or zero-) extended operands.
  function automatic logic [63:0] model_apply(input logic [63:0] hl, input int kind, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    case (kind)
      1:       return hl + p;
      2:       return hl - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic get_busy(input bit r2);
    return r2 ? bus2.Busy : bus.Busy;
  endfunction

  function automatic logic [63:0] get_hl(input bit r2);
    return r2 ? {bus2.Hi, bus2.Lo} : {bus.Hi, bus.Lo};
  endfunction

  task automatic set_req(input bit r2, input int kind, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
    if (r2) begin
      bus2.HiLoWrite = (kind == 0); bus2.Madd = (kind == 1); bus2.Msub = (kind == 2);
      bus2.Signed = sgn; bus2.OperandA = a; bus2.OperandB = b;
    end else begin
      bus.HiLoWrite = (kind == 0); bus.Madd = (kind == 1); bus.Msub = (kind == 2);
      bus.Signed = sgn; bus.OperandA = a; bus.OperandB = b;
    end
  endtask

  task automatic clear_req();
    bus.HiLoWrite = 1'b0;  bus.Madd = 1'b0;  bus.Msub = 1'b0;
    bus2.HiLoWrite = 1'b0; bus2.Madd = 1'b0; bus2.Msub = 1'b0;
  endtask

  // Issue one request and follow it to completion; returns busy length and Done around the end.
  task automatic run_op(input bit r2, input int kind, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int busy_cyc, output logic done_now,
                        output logic done_after);
    @(posedge clk); #1;
    set_req(r2, kind, sgn, a, b);
    @(posedge clk); #1;
    clear_req();
    busy_cyc = 0;
    for (int i = 0; i < 100 && get_busy(r2); i++) begin
      busy_cyc++;
      @(posedge clk); #1;
    end
    done_now = r2 ? bus2.Done : bus.Done;
    @(posedge clk); #1;
    done_after = r2 ? bus2.Done : bus.Done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({bus.Hi, bus.Lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {bus.Hi, bus.Lo}); end
    n_checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.Busy, bus.Done); end
    n_checks++; if ({bus2.Hi, bus2.Lo, bus2.Busy, bus2.Done} !== 66'h0) begin n_fail++; $display("FAIL reset_r2: got %h expected 0", {bus2.Hi, bus2.Lo, bus2.Busy, bus2.Done}); end
    rst = 1'b0;
    m_hl = 64'h0; m2_hl = 64'h0;
    @(posedge clk); #1;
    n_checks++; if (bus.Busy !== 1'b0 || {bus.Hi, bus.Lo} !== 64'h0) begin n_fail++; $display("FAIL post_reset_idle: got busy=%b hl=%h expected 0", bus.Busy, {bus.Hi, bus.Lo}); end
  endtask

  task automatic test_mult();
    int bc; logic dn, da;
    run_op(0, 0, 1'b1, 32'hFFFF_FFFD, 32'h7, bc, dn, da);
    m_hl = model_apply(m_hl, 0, 1'b1, 32'hFFFF_FFFD, 32'h7);
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mult_busy_len: got %0d expected 33", bc); end
    n_checks++; if (dn !== 1'b1 || da !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b%b expected 10", dn, da); end
    n_checks++; if (get_hl(0) !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h expected ffffffffffffffeb", get_hl(0)); end
    run_op(0, 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn, da);
    n_checks++; if (get_hl(0) !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h expected fffffffe00000001", get_hl(0)); end
    run_op(0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn, da);
    m_hl = model_apply(m_hl, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++; if (get_hl(0) !== 64'h1) begin n_fail++; $display("FAIL mult_m1xm1: got %h expected 1", get_hl(0)); end
  endtask

  task automatic test_madd_msub();
    int bc; logic dn, da;
    run_op(0, 0, 1'b1, 32'd5, 32'd6, bc, dn, da);
    run_op(0, 1, 1'b1, 32'd2, 32'd3, bc, dn, da);
    n_checks++; if (get_hl(0) !== 64'd36) begin n_fail++; $display("FAIL madd_36: got %h expected 24", get_hl(0)); end
    n_checks++; if (bc != 33 || dn !== 1'b1) begin n_fail++; $display("FAIL madd_timing: got busy=%0d done=%b expected 33/1", bc, dn); end
    run_op(0, 2, 1'b1, 32'd10, 32'd10, bc, dn, da);
    n_checks++; if (get_hl(0) !== 64'hFFFF_FFFF_FFFF_FFC0) begin n_fail++; $display("FAIL msub_neg64: got %h expected ffffffffffffffc0", get_hl(0)); end
    m_hl = 64'hFFFF_FFFF_FFFF_FFC0;
  endtask

  task automatic test_ignored();
    int bc; logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    @(posedge clk); #1; set_req(0, 0, 1'b1, a, b);
    @(posedge clk); #1; clear_req();
    m_hl = model_apply(m_hl, 0, 1'b1, a, b);
    repeat (4) @(posedge clk);
    #1;
    bus.Madd = 1'b1; bus.OperandA = 32'h1111_1111; bus.OperandB = 32'h2222_2222;
    @(posedge clk); #1; bus.Madd = 1'b0;
    bc = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin bc++; @(posedge clk); #1; end
    n_checks++; if (get_hl(0) !== m_hl) begin n_fail++; $display("FAIL madd_while_busy: got %h expected %h", get_hl(0), m_hl); end
    n_checks++; if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL busy_mult_done: got %b expected 1", bus.Done); end
    @(posedge clk); #1; bus.Madd = 1'b1; bus.Msub = 1'b1;
    @(posedge clk); #1; clear_req();
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL illegal_busy: got %b expected 0", bus.Busy); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || get_hl(0) !== m_hl) begin n_fail++; $display("FAIL illegal_state: got busy=%b done=%b hl=%h expected 0/0/%h", bus.Busy, bus.Done, get_hl(0), m_hl); end
  endtask

  task automatic test_back_to_back();
    int bc; logic [63:0] first; logic [31:0] a, b, c, d;
    a = rand_operand(); b = rand_operand(); c = $urandom(); d = $urandom();
    @(posedge clk); #1; set_req(0, 0, 1'b1, a, b);
    @(posedge clk); #1; clear_req();
    m_hl = model_apply(m_hl, 0, 1'b1, a, b); first = m_hl;
    bc = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin bc++; @(posedge clk); #1; end
    n_checks++; if (bus.Done !== 1'b1 || get_hl(0) !== first) begin n_fail++; $display("FAIL b2b_first: got done=%b hl=%h expected 1/%h", bus.Done, get_hl(0), first); end
    set_req(0, 1, 1'b0, c, d);
    @(posedge clk); #1; clear_req();
    n_checks++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", bus.Busy, bus.Done); end
    n_checks++; if (get_hl(0) !== first) begin n_fail++; $display("FAIL b2b_hold: got %h expected %h", get_hl(0), first); end
    m_hl = model_apply(m_hl, 1, 1'b0, c, d);
    bc = 0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin bc++; @(posedge clk); #1; end
    n_checks++; if (bc != 33 || bus.Done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_timing: got busy=%0d done=%b expected 33/1", bc, bus.Done); end
    n_checks++; if (get_hl(0) !== m_hl) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", get_hl(0), m_hl); end
  endtask

  task automatic test_radix2();
    int bc; logic dn, da;
    run_op(1, 0, 1'b1, 32'h7FFF_FFFF, 32'd2, bc, dn, da);
    m2_hl = model_apply(m2_hl, 0, 1'b1, 32'h7FFF_FFFF, 32'd2);
    n_checks++; if (bc != 17) begin n_fail++; $display("FAIL r2_busy_len: got %0d expected 17", bc); end
    n_checks++; if (dn !== 1'b1 || da !== 1'b0) begin n_fail++; $display("FAIL r2_done_pulse: got %b%b expected 10", dn, da); end
    n_checks++; if (get_hl(1) !== 64'h0000_0000_FFFF_FFFE) begin n_fail++; $display("FAIL r2_mult: got %h expected 00000000fffffffe", get_hl(1)); end
  endtask

  task automatic test_random();
    int bc; logic dn, da; bit r2; int kind; logic sgn; logic [31:0] a, b; logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      r2   = (i % 3 == 2);
      kind = $urandom_range(0, 2);
      sgn  = 1'($urandom_range(0, 1));
      a    = rand_operand();
      b    = rand_operand();
      run_op(r2, kind, sgn, a, b, bc, dn, da);
      if (r2) begin m2_hl = model_apply(m2_hl, kind, sgn, a, b); exp = m2_hl; end
      else    begin m_hl  = model_apply(m_hl, kind, sgn, a, b);  exp = m_hl;  end
      n_checks++; if (get_hl(r2) !== exp) begin n_fail++; $display("FAIL rand_result[%0d] r2=%0d op=%0d s=%b a=%h b=%h: got %h expected %h", i, r2, kind, sgn, a, b, get_hl(r2), exp); end
      n_checks++; if (bc != (r2 ? 17 : 33)) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, bc, r2 ? 17 : 33); end
      n_checks++; if (dn !== 1'b1 || da !== 1'b0) begin n_fail++; $display("FAIL rand_done[%0d]: got %b%b expected 10", i, dn, da); end
    end
  endtask

`ifdef HILO_MOVE_EN
  task automatic test_move();
    @(posedge clk); #1; bus.WriteHi = 1'b1; bus.MoveData = 32'h1234_5678;
    @(posedge clk); #1; bus.WriteHi = 1'b0;
    m_hl[63:32] = 32'h1234_5678;
    n_checks++; if (get_hl(0) !== m_hl || bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mthi: got %h busy=%b expected %h/0", get_hl(0), bus.Busy, m_hl); end
    @(posedge clk); #1;
    bus.WriteHi = 1'b1; bus.WriteLo = 1'b1; bus.MoveData = 32'h0000_0100;
    set_req(0, 1, 1'b0, 32'd3, 32'd5);
    @(posedge clk); #1; clear_req(); bus.WriteHi = 1'b0; bus.WriteLo = 1'b0;
    m_hl = {32'h0000_0100, 32'h0000_0100};
    n_checks++; if (get_hl(0) !== m_hl || bus.Busy !== 1'b1) begin n_fail++; $display("FAIL move_with_start: got %h busy=%b expected %h/1", get_hl(0), bus.Busy, m_hl); end
    m_hl = model_apply(m_hl, 1, 1'b0, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #1; bus.WriteLo = 1'b1; bus.MoveData = 32'hDEAD_BEEF;
    @(posedge clk); #1; bus.WriteLo = 1'b0;
    for (int i = 0; i < 100 && bus.Busy; i++) begin @(posedge clk); #1; end
    n_checks++; if (get_hl(0) !== m_hl) begin n_fail++; $display("FAIL move_while_busy: got %h expected %h", get_hl(0), m_hl); end
  endtask
`endif

  task automatic test_reset_mid();
    int bc, dc, bs; logic dn, da;
    run_op(0, 0, 1'b0, 32'd7, 32'd9, bc, dn, da);
    n_checks++; if (get_hl(0) !== 64'd63) begin n_fail++; $display("FAIL pre_reset_mult: got %h expected 3f", get_hl(0)); end
    @(posedge clk); #1; set_req(0, 0, 1'b1, 32'h1234_5678, 32'h0000_0FED);
    @(posedge clk); #1; clear_req();
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    n_checks++; if (bus.Busy !== 1'b0 || {bus.Hi, bus.Lo} !== 64'h0) begin n_fail++; $display("FAIL reset_abort: got busy=%b hl=%h expected 0/0", bus.Busy, {bus.Hi, bus.Lo}); end
    m_hl = 64'h0; m2_hl = 64'h0;
    @(posedge clk); #1; rst = 1'b0;
    dc = 0; bs = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) dc++;
      if (bus.Busy) bs++;
    end
    n_checks++; if (dc != 0 || bs != 0) begin n_fail++; $display("FAIL reset_no_done: got done=%0d busy=%0d expected 0/0", dc, bs); end
    run_op(0, 0, 1'b0, 32'd4, 32'd4, bc, dn, da);
    n_checks++; if (get_hl(0) !== 64'd16 || bc != 33) begin n_fail++; $display("FAIL after_reset_4x4: got %h busy=%0d expected 10/33", get_hl(0), bc); end
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    bus.Signed = 1'b0;  bus.OperandA = '0;  bus.OperandB = '0;
    bus2.Signed = 1'b0; bus2.OperandA = '0; bus2.OperandB = '0;
`ifdef HILO_MOVE_EN
    bus.WriteHi = 1'b0;  bus.WriteLo = 1'b0;  bus.MoveData = '0;
    bus2.WriteHi = 1'b0; bus2.WriteLo = 1'b0; bus2.MoveData = '0;
`endif
    test_reset();
    test_mult();
    test_madd_msub();
    test_ignored();
    test_back_to_back();
    test_radix2();
    test_random();
`ifdef HILO_MOVE_EN
    test_move();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
